// File: rtl/pc_sequencer_if.sv
// Fetch-head bus between the PC sequencer, the hazard/branch logic, the PC
// incrementer and instruction memory.
interface pc_sequencer_if;
  logic        imem_ready;
  logic        hazard_stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        replay_req;
  logic        replay_two;
  logic [15:0] pc_inc_next;
  logic [15:0] pc;
  logic        inc_stall;
  logic        inc_decrement;
  logic        fetch_valid;
  logic        flush;
  logic        timeout_err;

  modport slave (
    input  imem_ready, hazard_stall, branch_taken, branch_target,
           replay_req, replay_two, pc_inc_next,
    output pc, inc_stall, inc_decrement, fetch_valid, flush, timeout_err
  );

  modport master (
    output imem_ready, hazard_stall, branch_taken, branch_target,
           replay_req, replay_two, pc_inc_next,
    input  pc, inc_stall, inc_decrement, fetch_valid, flush, timeout_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner for the fetch stage: arbitrates branch, replay, stall
// and increment, parks redirects that arrive during imem wait, and runs a wait watchdog.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] pc_q, pc_next;
  logic        pend_valid, pend_valid_next;
  logic [15:0] pend_addr, pend_addr_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        flush_q, flush_next;
  logic        err_q, err_next;
  logic        inc_stall, inc_decrement;
  logic [15:0] branch_addr, rewind_addr;

  assign branch_addr = {bus.branch_target[15:1], 1'b0};
  // Private subtractor: the shared incrementer is held stalled while waiting.
  assign rewind_addr = pc_q - (bus.replay_two ? 16'd4 : 16'd2);

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next      = state;
    pc_next         = pc_q;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    wait_cnt_next   = wait_cnt;
    flush_next      = 1'b0;
    err_next        = err_q;
    inc_stall       = 1'b0;
    inc_decrement   = 1'b0;

    case (state)
      BOOT: state_next = RUN;

      RUN: begin
        if (bus.imem_ready) begin
          if (bus.branch_taken) begin
            pc_next    = branch_addr;
            flush_next = 1'b1;
          end else if (bus.replay_req) begin
            inc_decrement = 1'b1;
            inc_stall     = bus.replay_two;
            pc_next       = bus.pc_inc_next;
            flush_next    = 1'b1;
          end else if (bus.hazard_stall) begin
            inc_stall = 1'b1;
          end else begin
            pc_next = bus.pc_inc_next;
          end
        end else begin
          inc_stall     = bus.hazard_stall;
          state_next    = WAIT;
          wait_cnt_next = 8'd1;
          if (bus.branch_taken) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = branch_addr;
          end else if (bus.replay_req) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = rewind_addr;
          end
        end
      end

      WAIT: begin
        inc_stall = 1'b1;
        if (bus.branch_taken) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = branch_addr;
        end else if (bus.replay_req) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = rewind_addr;
        end
        if (bus.imem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
          // A request landing on the release cycle is applied immediately.
          if (pend_valid_next) begin
            pc_next         = pend_addr_next;
            flush_next      = 1'b1;
            pend_valid_next = 1'b0;
          end
        end else begin
          wait_cnt_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
      end

      default: state_next = BOOT;
    endcase

    if (state_next == WAIT && wait_cnt_next == TIMEOUT_CNT) err_next = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_VEC;
      pend_valid <= 1'b0;
      pend_addr  <= 16'h0000;
      wait_cnt   <= 8'd0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      pend_valid <= pend_valid_next;
      pend_addr  <= pend_addr_next;
      wait_cnt   <= wait_cnt_next;
      flush_q    <= flush_next;
      err_q      <= err_next;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.inc_stall     = inc_stall;
  assign bus.inc_decrement = inc_decrement;
  assign bus.fetch_valid   = (state == RUN) && bus.imem_ready && !bus.hazard_stall;
  assign bus.flush         = flush_q;
  assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the PC rules.
module tb_pc_sequencer;

  localparam logic [15:0] RESET_VEC = 16'h0100;
  localparam int          TIMEOUT   = 4;

  typedef enum {M_BOOT, M_RUN, M_WAIT} mode_t;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VEC(RESET_VEC), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational incrementer seen by the sequencer.
  assign bus.pc_inc_next = bus.inc_decrement ? (bus.pc - (bus.inc_stall ? 16'd4 : 16'd2))
                         : (bus.inc_stall ? bus.pc : bus.pc + 16'd2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  mode_t       m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_pend[$];
  int          m_cnt;
  logic        m_flush;
  logic        m_err;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = RESET_VEC;
    m_pend.delete();
    m_cnt   = 0;
    m_flush = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic rdy, hz, br, input logic [15:0] tgt,
                            input logic rp, two);
    logic [15:0] req;
    req     = br ? {tgt[15:1], 1'b0} : m_pc - (two ? 16'd4 : 16'd2);
    m_flush = 1'b0;
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN:
        if (rdy) begin
          if (br || rp) begin
            m_pc    = req;
            m_flush = 1'b1;
          end else if (!hz) begin
            m_pc = m_pc + 16'd2;
          end
        end else begin
          m_mode = M_WAIT;
          m_cnt  = 1;
          if (br || rp) m_pend.push_back(req);
        end
      default: begin
        if (br || rp) begin
          m_pend.delete();
          m_pend.push_back(req);
        end
        if (rdy) begin
          m_mode = M_RUN;
          m_cnt  = 0;
          if (m_pend.size() > 0) begin
            m_pc    = m_pend.pop_front();
            m_flush = 1'b1;
          end
        end else if (m_cnt < 255) begin
          m_cnt++;
        end
      end
    endcase
    if (m_cnt >= TIMEOUT) m_err = 1'b1;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, clock, check state.
  task automatic cycle(input logic rdy, hz, br, input logic [15:0] tgt,
                       input logic rp, two);
    logic exp_fv, exp_st, exp_dec;
    bus.imem_ready    = rdy;
    bus.hazard_stall  = hz;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.replay_req    = rp;
    bus.replay_two    = two;
    #3;
    exp_fv  = (m_mode == M_RUN) && rdy && !hz;
    exp_st  = 1'b0;
    exp_dec = 1'b0;
    if (m_mode == M_WAIT) exp_st = 1'b1;
    else if (m_mode == M_RUN) begin
      if (rdy && br) exp_st = 1'b0;
      else if (rdy && rp) begin
        exp_st  = two;
        exp_dec = 1'b1;
      end else exp_st = hz;
    end
    check("fetch_valid", 16'(bus.fetch_valid), 16'(exp_fv));
    check("inc_stall", 16'(bus.inc_stall), 16'(exp_st));
    check("inc_decrement", 16'(bus.inc_decrement), 16'(exp_dec));
    @(posedge clk);
    model_step(rdy, hz, br, tgt, rp, two);
    #1;
    check("pc", bus.pc, m_pc);
    check("flush", 16'(bus.flush), 16'(m_flush));
    check("timeout_err", 16'(bus.timeout_err), 16'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [15:0] tgt);
    cycle(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset();
    bus.imem_ready   = 1'b1;
    bus.hazard_stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.replay_req   = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_pc", bus.pc, RESET_VEC);
    check("rst_flush", 16'(bus.flush), 16'h0);
    check("rst_timeout_err", 16'(bus.timeout_err), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic rdy, hz, br, rp, two;
    logic [15:0] tgt;
    rst_n             = 1'b1;
    bus.imem_ready    = 1'b1;
    bus.hazard_stall  = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0;
    bus.replay_req    = 1'b0;
    bus.replay_two    = 1'b0;
    #1;
    do_reset();

    // Boot then sequential fetch: 0100, 0102, 0104
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("boot_pc", bus.pc, 16'h0100);
    idle(2);
    check("seq_pc", bus.pc, 16'h0104);

    // Wrap across 16'hFFFE
    jump(16'hFFFC);
    idle(2);
    check("wrap_pc", bus.pc, 16'h0000);
    idle(1);
    check("wrap_pc2", bus.pc, 16'h0002);

    // Hazard hold
    jump(16'h0040);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check("hazard_hold", bus.pc, 16'h0040);
    idle(1);
    check("hazard_resume", bus.pc, 16'h0042);

    // Replay by 2 and by 4
    jump(16'h0050);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("replay2", bus.pc, 16'h004E);
    jump(16'h0050);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check("replay4", bus.pc, 16'h004C);
    idle(1);

    // Branch beats same-cycle replay, odd target bit dropped
    jump(16'h0060);
    cycle(1'b1, 1'b0, 1'b1, 16'h1233, 1'b1, 1'b1);
    check("branch_prio", bus.pc, 16'h1232);
    idle(1);

    // Wait with a parked branch, watchdog trips, then release
    jump(16'h0070);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("wait_pc", bus.pc, 16'h0070);
    check("wait_err", 16'(bus.timeout_err), 16'h1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("wait_exit_pc", bus.pc, 16'h0200);
    check("wait_exit_flush", 16'(bus.flush), 16'h1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      hz  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 7) == 0);
      rp  = ($urandom_range(0, 7) == 0);
      two = 1'($urandom_range(0, 1));
      tgt = 16'($urandom);
      cycle(rdy, hz, br, tgt, rp, two);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
